icache_nway: RTL

//  Parametrised N-way set-associative read-only instruction cache: successor of the fixed 4-set/2-way Icache.

---
 rtl/icache_nway.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/icache_nway.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : icache_nway                                                  |
// | Purpose : Parametrised N-way set-associative read-only instruction     |
// |           cache between the fetch port and instruction memory.         |
// |           Round-robin replacement per set, flush input, hit/miss       |
// |           performance counters.                                        |
// | Ports   : clk, proc_reset (async, active-high)                         |
// |           proc_read/write/addr/wdata -> proc_stall, proc_rdata         |
// |           flush (single-cycle invalidate-all pulse)                    |
// |           mem_read/write/addr/wdata <- mem_rdata, mem_ready            |
// |           hit_count, miss_count (wrapping)                             |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module icache_nway #(
    parameter int ADDR_W = 30,
    parameter int SETS   = 4,
    parameter int WAYS   = 2,
    parameter int WORDS  = 4,
    parameter int CNT_W  = 32
) (
    input  logic                                 clk,
    input  logic                                 proc_reset,
    input  logic                                 proc_read,
    input  logic                                 proc_write,
    input  logic [ADDR_W-1:0]                    proc_addr,
    input  logic [31:0]                          proc_wdata,
    output logic                                 proc_stall,
    output logic [31:0]                          proc_rdata,
    input  logic                                 flush,
    output logic                                 mem_read,
    output logic                                 mem_write,
    output logic [ADDR_W-$clog2(WORDS)-1:0]      mem_addr,
    input  logic [32*WORDS-1:0]                  mem_rdata,
    output logic [32*WORDS-1:0]                  mem_wdata,
    input  logic                                 mem_ready,
    output logic [CNT_W-1:0]                     hit_count,
    output logic [CNT_W-1:0]                     miss_count
);

    localparam int OFF_W  = $clog2(WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LADR_W = ADDR_W - OFF_W;
    localparam int LINE_W = 32 * WORDS;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALLOC = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                pend_q;
    logic [LADR_W-1:0]   mem_addr_q;
    logic [31:0]         rdata_q;
    logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q;
    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAY_W-1:0]    rr_q    [SETS];
    logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
    logic [LINE_W-1:0]   data_q  [SETS][WAYS];

    logic [IDX_W-1:0]    idx_w;
    logic [OFF_W-1:0]    off_w;
    logic [TAG_W-1:0]    tag_w;
    logic [OFF_W+4:0]    bit_w;
    logic                hit_w, any_inv_w;
    logic [WAY_W-1:0]    hit_way_w, victim_w, rr_next_w;

    logic                stall_d, mread_d, do_hit, do_miss, do_fill, do_flush, pend_set;
    logic [LADR_W-1:0]   maddr_d;
    logic [31:0]         rdata_d;

    // Write-side inputs exist only for port compatibility with the fetch bus.
    logic                unused_ok;
    assign unused_ok = ^{proc_write, proc_wdata};

    assign idx_w = proc_addr[OFF_W +: IDX_W];
    assign off_w = proc_addr[OFF_W-1:0];
    assign tag_w = proc_addr[ADDR_W-1 -: TAG_W];
    assign bit_w = {off_w, 5'b00000};

    // Tag compare across all ways of the addressed set.
    always_comb begin
        hit_w     = 1'b0;
        hit_way_w = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx_w][w] && (tag_q[idx_w][w] == tag_w)) begin
                hit_w     = 1'b1;
                hit_way_w = WAY_W'(w);
            end
        end
    end

    // Victim: lowest-index invalid way; round-robin pointer only when the set is full.
    always_comb begin
        any_inv_w = 1'b0;
        victim_w  = rr_q[idx_w];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx_w][w]) begin
                any_inv_w = 1'b1;
                victim_w  = WAY_W'(w);
            end
        end
    end

    assign rr_next_w = (rr_q[idx_w] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx_w] + 1'b1;

    // Next-state and output decode. Everything is forced inactive while reset
    // is asserted so a mid-refill reset drops mem_read without a clock edge.
    always_comb begin
        state_d  = state_q;
        stall_d  = 1'b0;
        mread_d  = 1'b0;
        maddr_d  = mem_addr_q;
        rdata_d  = rdata_q;
        do_hit   = 1'b0;
        do_miss  = 1'b0;
        do_fill  = 1'b0;
        do_flush = 1'b0;
        pend_set = 1'b0;
        if (!proc_reset) begin
            case (state_q)
                S_IDLE: begin
                    if (flush || pend_q) begin
                        stall_d = 1'b1;
                        state_d = S_FLUSH;
                    end else if (proc_read) begin
                        if (hit_w) begin
                            rdata_d = data_q[idx_w][hit_way_w][bit_w +: 32];
                            do_hit  = 1'b1;
                        end else begin
                            stall_d = 1'b1;
                            mread_d = 1'b1;
                            maddr_d = proc_addr[ADDR_W-1:OFF_W];
                            do_miss = 1'b1;
                            state_d = S_ALLOC;
                        end
                    end
                end
                S_ALLOC: begin
                    mread_d  = 1'b1;
                    pend_set = flush;
                    if (mem_ready) begin
                        rdata_d = mem_rdata[bit_w +: 32];
                        do_fill = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stall_d = 1'b1;
                    end
                end
                S_FLUSH: begin
                    stall_d  = 1'b1;
                    do_flush = 1'b1;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            pend_q     <= 1'b0;
            mem_addr_q <= '0;
            rdata_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            mem_addr_q <= maddr_d;
            rdata_q    <= rdata_d;
            if (do_hit)  hit_cnt_q  <= hit_cnt_q + 1'b1;
            if (do_miss) miss_cnt_q <= miss_cnt_q + 1'b1;
            if (do_flush) begin
                pend_q <= 1'b0;
                for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
            end else if (pend_set) begin
                pend_q <= 1'b1;
            end
            if (do_fill) begin
                valid_q[idx_w][victim_w] <= 1'b1;
                if (!any_inv_w) rr_q[idx_w] <= rr_next_w;
            end
        end
    end

    // Tag/data storage carries no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (do_fill) begin
            tag_q[idx_w][victim_w]  <= tag_w;
            data_q[idx_w][victim_w] <= mem_rdata;
        end
    end

    assign proc_stall = stall_d;
    assign proc_rdata = rdata_d;
    assign mem_read   = mread_d;
    assign mem_addr   = maddr_d;
    assign mem_write  = 1'b0;
    assign mem_wdata  = '0;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule
`default_nettype wire
